// File: rtl/rect_to_hex_pipe.sv
// Three-stage pixel-to-hex converter: centre offset, sector classification against +/-sqrt(3)*dx,
// then radius halving/saturation and board rotation. All stages advance together under backpressure.
module rect_to_hex_pipe #(
  parameter int unsigned W     = 10,
  parameter int unsigned CX    = 320,
  parameter int unsigned CY    = 240,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ROOT3 = 1773
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] px,
  input  logic [W-1:0] py,
  input  logic [2:0]   rot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   sector,
  output logic [W-1:0] radius,
  output logic         sat
);

  localparam int unsigned PW = W + FRAC + 3;

  localparam logic signed [W:0]    CxS    = (W+1)'(CX);
  localparam logic signed [W:0]    CyS    = (W+1)'(CY);
  localparam logic signed [PW-1:0] Root3S = PW'(ROOT3);

  logic advance;

  // Stage 1: centred coordinates and reduced rotation
  logic                v1_q, v1_d;
  logic signed [W:0]   dx1_q, dx1_d;
  logic signed [W:0]   dy1_q, dy1_d;
  logic [2:0]          rot1_q, rot1_d;

  // Stage 2: raw sector and unhalved radius
  logic                v2_q, v2_d;
  logic [2:0]          sec2_q, sec2_d;
  logic signed [W+2:0] s2_q, s2_d;
  logic [2:0]          rot2_q, rot2_d;

  // Stage 3: registered outputs
  logic                out_valid_q, out_valid_d;
  logic [2:0]          sector_q, sector_d;
  logic [W-1:0]        radius_q, radius_d;
  logic                sat_q, sat_d;

  logic signed [PW-1:0] prod;
  logic signed [W+2:0]  r3x, nr3x, yx;
  logic                 y_pos;
  logic [W+2:0]         rr;
  logic [3:0]           sec_sum, sec_wrap;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    v1_d   = v1_q;
    dx1_d  = dx1_q;
    dy1_d  = dy1_q;
    rot1_d = rot1_q;
    if (advance) begin
      v1_d   = in_valid;
      dx1_d  = $signed({1'b0, px}) - CxS;
      dy1_d  = $signed({1'b0, py}) - CyS;
      rot1_d = (rot >= 3'd6) ? rot - 3'd6 : rot;
    end
  end

  always_comb begin
    // Arithmetic shift gives floor, so negative dx rounds away from zero.
    prod  = PW'(dx1_q) * Root3S;
    r3x   = (W+3)'(prod >>> FRAC);
    nr3x  = -r3x;
    yx    = (W+3)'(dy1_q);
    y_pos = !yx[W+2] && (yx != '0);

    v2_d   = v2_q;
    sec2_d = sec2_q;
    s2_d   = s2_q;
    rot2_d = rot2_q;
    if (advance) begin
      v2_d   = v1_q;
      rot2_d = rot1_q;
      if (y_pos) begin
        if (yx < r3x) begin
          sec2_d = 3'd0;
          s2_d   = yx + r3x;
        end else if (yx < nr3x) begin
          sec2_d = 3'd2;
          s2_d   = yx + nr3x;
        end else begin
          sec2_d = 3'd1;
          s2_d   = yx + yx;
        end
      end else begin
        if (yx > r3x) begin
          sec2_d = 3'd3;
          s2_d   = nr3x - yx;
        end else if (yx > nr3x) begin
          sec2_d = 3'd5;
          s2_d   = r3x - yx;
        end else begin
          sec2_d = 3'd4;
          s2_d   = -(yx + yx);
        end
      end
    end
  end

  always_comb begin
    rr       = s2_q >> 1;
    sec_sum  = {1'b0, sec2_q} + {1'b0, rot2_q};
    sec_wrap = sec_sum - 4'd6;

    out_valid_d = out_valid_q;
    sector_d    = sector_q;
    radius_d    = radius_q;
    sat_d       = sat_q;
    if (advance) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        sat_d    = |rr[W+2:W];
        radius_d = (|rr[W+2:W]) ? '1 : rr[W-1:0];
        sector_d = (sec_sum >= 4'd6) ? sec_wrap[2:0] : sec_sum[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      dx1_q       <= '0;
      dy1_q       <= '0;
      rot1_q      <= '0;
      v2_q        <= 1'b0;
      sec2_q      <= '0;
      s2_q        <= '0;
      rot2_q      <= '0;
      out_valid_q <= 1'b0;
      sector_q    <= '0;
      radius_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      dx1_q       <= dx1_d;
      dy1_q       <= dy1_d;
      rot1_q      <= rot1_d;
      v2_q        <= v2_d;
      sec2_q      <= sec2_d;
      s2_q        <= s2_d;
      rot2_q      <= rot2_d;
      out_valid_q <= out_valid_d;
      sector_q    <= sector_d;
      radius_q    <= radius_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sector    = sector_q;
  assign radius    = radius_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_rect_to_hex_pipe.sv
// Bench for rect_to_hex_pipe: default-centre instance plus a zero-centre instance for saturation,
// each checked by a model-driven scoreboard and directed known-answer vectors.
module tb_rect_to_hex_pipe;

  logic       clk = 1'b0;
  logic       reset;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
  logic [9:0] a_px, a_py, a_radius;
  logic [2:0] a_rot, a_sector;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
  logic [9:0] b_px, b_py, b_radius;
  logic [2:0] b_rot, b_sector;

  int n_cmp = 0;
  int n_err = 0;
  int n_out_a = 0;

  logic [13:0] exp_a[$];
  logic [13:0] exp_b[$];

  always #5 clk = ~clk;

  rect_to_hex_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .px(a_px), .py(a_py), .rot(a_rot), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sector(a_sector), .radius(a_radius), .sat(a_sat)
  );

  rect_to_hex_pipe #(.W(10), .CX(0), .CY(0), .FRAC(10), .ROOT3(1773)) u_sat (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .px(b_px), .py(b_py), .rot(b_rot), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sector(b_sector), .radius(b_radius), .sat(b_sat)
  );

  // Reference: {sector[2:0], sat, radius[9:0]}
  function automatic logic [13:0] model(input int px, input int py, input int rot,
                                        input int cx, input int cy);
    int dx, dy, r3, nr3, s, rr, sec, rad;
    logic [13:0] res;
    dx  = px - cx;
    dy  = py - cy;
    r3  = (dx * 1773) >>> 10;
    nr3 = -r3;
    if (dy > 0) begin
      if (dy < r3) begin sec = 0; s = dy + r3; end
      else if (dy < nr3) begin sec = 2; s = dy + nr3; end
      else begin sec = 1; s = 2 * dy; end
    end else begin
      if (dy > r3) begin sec = 3; s = -dy + nr3; end
      else if (dy > nr3) begin sec = 5; s = -dy + r3; end
      else begin sec = 4; s = -2 * dy; end
    end
    rr  = s / 2;
    rad = (rr > 1023) ? 1023 : rr;
    sec = (sec + (rot % 6)) % 6;
    res[13:11] = sec[2:0];
    res[10]    = (rr > 1023);
    res[9:0]   = rad[9:0];
    return res;
  endfunction

  // Scoreboard: compare completed handshakes, then record accepted inputs.
  task automatic sb_step();
    logic [13:0] e;
    @(negedge clk);
    if (reset) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        n_cmp++;
        n_out_a++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL sb_a_extra: got sec=%0d sat=%0d rad=%0d, required no output",
                   a_sector, a_sat, a_radius);
        end else begin
          e = exp_a.pop_front();
          if ({a_sector, a_sat, a_radius} !== e) begin
            n_err++;
            $display("FAIL sb_a: got sec=%0d sat=%0d rad=%0d, required sec=%0d sat=%0d rad=%0d",
                     a_sector, a_sat, a_radius, e[13:11], e[10], e[9:0]);
          end
        end
      end
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL sb_b_extra: got sec=%0d sat=%0d rad=%0d, required no output",
                   b_sector, b_sat, b_radius);
        end else begin
          e = exp_b.pop_front();
          if ({b_sector, b_sat, b_radius} !== e) begin
            n_err++;
            $display("FAIL sb_b: got sec=%0d sat=%0d rad=%0d, required sec=%0d sat=%0d rad=%0d",
                     b_sector, b_sat, b_radius, e[13:11], e[10], e[9:0]);
          end
        end
      end
      if (a_in_valid && a_in_ready) exp_a.push_back(model(a_px, a_py, a_rot, 320, 240));
      if (b_in_valid && b_in_ready) exp_b.push_back(model(b_px, b_py, b_rot, 0, 0));
    end
  endtask

  task automatic tick();
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0 && !a_out_valid && !b_out_valid) break;
      tick();
    end
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", exp_a.size(),
               exp_b.size());
    end
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    a_in_valid = 1'b1; a_px = 10'd420; a_py = 10'd250; a_rot = 3'd0;
    b_in_valid = 1'b1; b_px = 10'd5;   b_py = 10'd7;   b_rot = 3'd0;
    repeat (3) tick();
    reset = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    n_cmp += 5;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", a_out_valid); end
    if (a_sector !== 3'd0) begin n_err++; $display("FAIL rst_sector: got %0d, required 0", a_sector); end
    if (a_radius !== 10'd0) begin n_err++; $display("FAIL rst_radius: got %0d, required 0", a_radius); end
    if (a_sat !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b, required 0", a_sat); end
    if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", a_in_ready); end
    seen = 0;
    repeat (6) begin
      tick();
      if (a_out_valid || b_out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_drop: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_directed();
    int tpx[7]  = '{420, 220, 220, 320, 320, 420, 420};
    int tpy[7]  = '{250, 230, 230, 240, 290, 413, 240};
    int trot[7] = '{0, 0, 4, 0, 0, 0, 0};
    int tsec[7] = '{0, 3, 1, 4, 1, 1, 5};
    int trad[7] = '{91, 92, 92, 0, 50, 173, 86};
    int lat;
    for (int i = 0; i < 7; i++) begin
      a_px = 10'(tpx[i]); a_py = 10'(tpy[i]); a_rot = 3'(trot[i]);
      a_in_valid = 1'b1;
      sb_step();
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 1;
      while (lat < 10) begin
        sb_step();
        if (a_out_valid) break;
        @(posedge clk); #1;
        lat++;
      end
      n_cmp += 4;
      if (lat != 3) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d, required 3", i, lat); end
      if (a_sector !== 3'(tsec[i])) begin
        n_err++; $display("FAIL dir_sector[%0d]: got %0d, required %0d", i, a_sector, tsec[i]);
      end
      if (a_radius !== 10'(trad[i])) begin
        n_err++; $display("FAIL dir_radius[%0d]: got %0d, required %0d", i, a_radius, trad[i]);
      end
      if (a_sat !== 1'b0) begin n_err++; $display("FAIL dir_sat[%0d]: got %b, required 0", i, a_sat); end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_saturation();
    int tpx[4]  = '{1023, 1023, 0, 1023};
    int tpy[4]  = '{1023, 1023, 0, 0};
    int trot[4] = '{0, 7, 0, 0};
    int tsec[4] = '{0, 1, 4, 5};
    int trad[4] = '{1023, 1023, 0, 885};
    int tsat[4] = '{1, 1, 0, 0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      b_px = 10'(tpx[i]); b_py = 10'(tpy[i]); b_rot = 3'(trot[i]);
      b_in_valid = 1'b1;
      sb_step();
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 1;
      while (lat < 10) begin
        sb_step();
        if (b_out_valid) break;
        @(posedge clk); #1;
        lat++;
      end
      n_cmp += 3;
      if (b_sector !== 3'(tsec[i])) begin
        n_err++; $display("FAIL sat_sector[%0d]: got %0d, required %0d", i, b_sector, tsec[i]);
      end
      if (b_radius !== 10'(trad[i])) begin
        n_err++; $display("FAIL sat_radius[%0d]: got %0d, required %0d", i, b_radius, trad[i]);
      end
      if (b_sat !== 1'(tsat[i])) begin
        n_err++; $display("FAIL sat_flag[%0d]: got %b, required %0d", i, b_sat, tsat[i]);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int rpx[8], rpy[8], rrot[8];
    int idx, c, start_out;
    logic       stalled;
    logic [14:0] held;
    for (int i = 0; i < 8; i++) begin
      rpx[i]  = $urandom_range(0, 1023);
      rpy[i]  = $urandom_range(0, 1023);
      rrot[i] = $urandom_range(0, 7);
    end
    idx = 0;
    c = 0;
    stalled = 1'b0;
    held = '0;
    start_out = n_out_a;
    while ((idx < 8 || exp_a.size() > 0) && c < 40) begin
      a_out_ready = !(c >= 4 && c <= 6);
      a_in_valid  = (idx < 8);
      if (idx < 8) begin
        a_px = 10'(rpx[idx]); a_py = 10'(rpy[idx]); a_rot = 3'(rrot[idx]);
      end
      sb_step();
      if (a_out_valid && !a_out_ready) begin
        n_cmp++;
        if (a_in_ready !== 1'b0) begin
          n_err++; $display("FAIL stall_in_ready[c%0d]: got %b, required 0", c, a_in_ready);
        end
      end
      if (stalled) begin
        n_cmp++;
        if ({a_out_valid, a_sector, a_sat, a_radius} !== held) begin
          n_err++;
          $display("FAIL stall_hold[c%0d]: got %h, required %h", c,
                   {a_out_valid, a_sector, a_sat, a_radius}, held);
        end
      end
      stalled = a_out_valid && !a_out_ready;
      held = {a_out_valid, a_sector, a_sat, a_radius};
      if (a_in_valid && a_in_ready) idx++;
      @(posedge clk); #1;
      c++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    n_cmp++;
    if (n_out_a - start_out != 8 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs (%0d pending), required 8 (0 pending)",
               n_out_a - start_out, exp_a.size());
    end
    drain();
  endtask

  task automatic test_reset_flush();
    int seen, lat;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_px = 10'(100 + 50 * i); a_py = 10'(60 + 40 * i); a_rot = 3'(i);
      a_in_valid = 1'b1;
      tick();
    end
    reset = 1'b1;
    a_px = 10'd700; a_py = 10'd20; a_rot = 3'd2;
    tick();
    reset = 1'b0;
    a_in_valid = 1'b0;
    n_cmp += 4;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b, required 0", a_out_valid); end
    if (a_radius !== 10'd0) begin n_err++; $display("FAIL flush_radius: got %0d, required 0", a_radius); end
    if (a_sat !== 1'b0) begin n_err++; $display("FAIL flush_sat: got %b, required 0", a_sat); end
    if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b, required 1", a_in_ready); end
    seen = 0;
    repeat (5) begin
      tick();
      if (a_out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL flush_ghost: got %0d valid cycles, required 0", seen); end
    a_px = 10'd420; a_py = 10'd250; a_rot = 3'd3;
    a_in_valid = 1'b1;
    sb_step();
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      sb_step();
      if (a_out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp += 2;
    if (lat != 3) begin n_err++; $display("FAIL flush_latency: got %0d, required 3", lat); end
    if (a_sector !== 3'd3) begin n_err++; $display("FAIL flush_sector: got %0d, required 3", a_sector); end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_px = '0; a_py = '0; a_rot = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_px = '0; b_py = '0; b_rot = '0; b_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_saturation();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
